// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM
// between an instruction-fetch port (0) and a data port (1).
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);
  localparam bit         LAT1     = (RD_LATENCY == 1);

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                owner_q, owner_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                rv0_q, rv0_d;
  logic                rv1_q, rv1_d;
  logic                win;
  logic                rv_set;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    win        = 1'b0;
    rv_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_gnt only moves when both ports contend
        if (m0_req && m1_req) begin
          win        = ~last_gnt_q;
          last_gnt_d = ~last_gnt_q;
        end else begin
          win = m1_req;
        end
        if (m0_req || m1_req) begin
          en_d    = 1'b1;
          we_d    = win ? m1_we : m0_we;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          gnt0_d  = ~win;
          gnt1_d  = win;
          owner_d = win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          rv_set  = LAT1;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d  = cnt_q - 2'd1;
          rv_set = (cnt_q == 2'd1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rv0_d = rv_set & ~owner_q;
    rv1_d = rv_set & owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= 2'd0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? mem_rdata : '0;
  assign m1_rdata  = rv1_q ? mem_rdata : '0;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against RAM models
// with read latency 1 (dut_a) and 3 (dut_b).
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid;
  logic [15:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
  logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid;
  logic [15:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
  logic        a_mem_en, a_mem_we;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
  logic [15:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
  logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
  logic [15:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr),
    .m0_wdata(a_m0_wdata), .m0_gnt(a_m0_gnt),
    .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr),
    .m1_wdata(a_m1_wdata), .m1_gnt(a_m1_gnt),
    .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr),
    .m0_wdata(b_m0_wdata), .m0_gnt(b_m0_gnt),
    .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr),
    .m1_wdata(b_m1_wdata), .m1_gnt(b_m1_gnt),
    .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  logic [15:0] ram_a [1024];
  logic [15:0] ram_b [1024];
  logic [15:0] rd_a, p0_b, p1_b, p2_b;
  logic        pl_we, pl_sel;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_we && !pl_sel) ram_a[pl_addr] <= pl_data;
    if (pl_we && pl_sel) ram_b[pl_addr] <= pl_data;
    if (a_mem_en) begin
      if (a_mem_we) ram_a[a_mem_addr[9:0]] <= a_mem_wdata;
      else rd_a <= ram_a[a_mem_addr[9:0]];
    end
    if (b_mem_en) begin
      if (b_mem_we) ram_b[b_mem_addr[9:0]] <= b_mem_wdata;
      else p0_b <= ram_b[b_mem_addr[9:0]];
    end
    p1_b <= p0_b;
    p2_b <= p1_b;
  end

  assign a_mem_rdata = rd_a;
  assign b_mem_rdata = p2_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pl(input bit sel, input logic [9:0] adr,
                    input logic [15:0] d);
    pl_sel  = sel;
    pl_addr = adr;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic chk_a_zero(input string tag);
    chk(tag, {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid,
              a_mem_en, a_mem_we}, 0);
    chk(tag, {a_mem_addr, a_mem_wdata}, 0);
  endtask

  task automatic chk_b_zero(input string tag);
    chk(tag, {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid,
              b_mem_en, b_mem_we}, 0);
    chk(tag, {b_mem_addr, b_mem_wdata}, 0);
  endtask

  int          i0, i1, ng, nr0, nr1, w0, w1, maxw, bad, nrd;
  logic [15:0] e0, e1;
  logic [15:0] sb [16];
  bit          pd0, pd1, prev_en, got;

  initial begin
    rst = 1'b1;
    pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = '0; a_m1_wdata = '0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk_a_zero("reset_a");
    chk_b_zero("reset_b");

    pl(1'b0, 10'h010, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      pl(1'b0, 10'h100 + 10'(i), 16'hA000 + 16'(i));
      pl(1'b0, 10'h200 + 10'(i), 16'hB000 + 16'(i));
    end
    pl(1'b1, 10'h030, 16'hC0DE);
    pl(1'b1, 10'h031, 16'h5A5A);

    // m0 read after reset
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 16'h0010;
    tick();
    chk("t1_gnt", {a_m0_gnt, a_m1_gnt, a_mem_en, a_mem_we}, 4'b1010);
    chk("t1_addr", a_mem_addr, 16'h0010);
    a_m0_req = 0;
    tick();
    chk("t1_rv", {a_m0_rvalid, a_m1_rvalid, a_mem_en}, 3'b100);
    chk("t1_rdata", a_m0_rdata, 16'hBEEF);
    chk("t1_m1_rdata", a_m1_rdata, 16'h0000);
    tick();
    chk("t1_done", {a_m0_rvalid, a_m0_gnt, a_mem_en}, 0);

    // m1 write, then readback through m0
    a_m1_req = 1; a_m1_we = 1;
    a_m1_addr = 16'h0042; a_m1_wdata = 16'h1234;
    tick();
    chk("t2_wr", {a_m1_gnt, a_m0_gnt, a_mem_en, a_mem_we}, 4'b1011);
    chk("t2_addr", a_mem_addr, 16'h0042);
    chk("t2_wdata", a_mem_wdata, 16'h1234);
    a_m1_req = 0; a_m1_we = 0;
    tick();
    chk("t2_after", {a_mem_en, a_mem_we, a_m1_rvalid, a_m1_gnt}, 0);
    chk("t2_hold", {a_mem_addr, a_mem_wdata}, {16'h0042, 16'h1234});
    tick();
    chk("t2_norv", a_m1_rvalid, 0);
    a_m0_req = 1; a_m0_addr = 16'h0042;
    tick();
    chk("t2_rb_gnt", {a_m0_gnt, a_mem_en, a_mem_we}, 3'b110);
    a_m0_req = 0;
    tick();
    chk("t2_rb", {a_m0_rvalid, a_m0_rdata}, {1'b1, 16'h1234});
    tick();

    // contention from a fresh reset: strict alternation
    rst = 1;
    tick();
    rst = 0;
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 16'h0100;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 16'h0200;
    i0 = 0; i1 = 0; ng = 0; nr0 = 0; nr1 = 0;
    for (int c = 0; c < 60 && (nr0 < 4 || nr1 < 4); c++) begin
      tick();
      if (a_m0_gnt || a_m1_gnt) begin
        chk("t3_order", a_m1_gnt, ng[0]);
        ng++;
      end
      if (a_m0_rvalid) begin
        chk("t3_rd0", a_m0_rdata, e0);
        nr0++;
      end
      if (a_m1_rvalid) begin
        chk("t3_rd1", a_m1_rdata, e1);
        nr1++;
      end
      if (a_m0_gnt) begin
        e0 = 16'hA000 + 16'(i0);
        i0++;
        if (i0 < 4) a_m0_addr = 16'h0100 + 16'(i0);
        else a_m0_req = 0;
      end
      if (a_m1_gnt) begin
        e1 = 16'hB000 + 16'(i1);
        i1++;
        if (i1 < 4) a_m1_addr = 16'h0200 + 16'(i1);
        else a_m1_req = 0;
      end
    end
    chk("t3_n0", nr0, 4);
    chk("t3_n1", nr1, 4);
    tick();

    // latency 3, m1 arrives during WAIT
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 16'h0030;
    tick();
    chk("t4_gnt", {b_m0_gnt, b_m1_gnt, b_mem_en, b_mem_we}, 4'b1010);
    chk("t4_addr", b_mem_addr, 16'h0030);
    b_m0_req = 0;
    tick();
    chk("t4_w1", {b_m0_rvalid, b_m1_gnt, b_mem_en}, 0);
    b_m1_req = 1; b_m1_we = 0; b_m1_addr = 16'h0031;
    tick();
    chk("t4_w2", {b_m0_rvalid, b_m1_gnt}, 0);
    tick();
    chk("t4_rv", {b_m0_rvalid, b_m1_gnt, b_m1_rvalid}, 3'b100);
    chk("t4_rdata", b_m0_rdata, 16'hC0DE);
    tick();
    chk("t4_idle", {b_m0_rvalid, b_m1_gnt}, 0);
    tick();
    chk("t4_m1gnt", {b_m1_gnt, b_mem_en}, 2'b11);
    chk("t4_m1addr", b_mem_addr, 16'h0031);
    b_m1_req = 0;
    repeat (3) tick();
    chk("t4_m1rd", {b_m1_rvalid, b_m1_rdata}, {1'b1, 16'h5A5A});
    tick();

    // reset pulse during WAIT aborts the read
    b_m0_req = 1; b_m0_addr = 16'h0030;
    tick();
    chk("t5_gnt", {b_m0_gnt, b_mem_en}, 2'b11);
    b_m0_req = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk_b_zero("t5_rst");
    b_m0_req = 1; b_m1_req = 1;
    tick();
    chk("t5_first", {b_m0_gnt, b_m1_gnt, b_m0_rvalid}, 3'b100);
    chk("t5_addr", b_mem_addr, 16'h0030);
    b_m0_req = 0;
    tick();
    chk("t5_norv", {b_m0_rvalid, b_m1_rvalid}, 0);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (b_m1_gnt) begin
        got = 1;
        b_m1_req = 0;
      end
    end
    chk("t5_m1", got, 1);
    repeat (5) tick();

    // random traffic against a scoreboard on dut_a
    for (int i = 0; i < 16; i++) begin
      pl(1'b0, 10'(i), 16'h7000 + 16'(i));
      sb[i] = 16'h7000 + 16'(i);
    end
    pd0 = 0; pd1 = 0; w0 = 0; w1 = 0; maxw = 0; bad = 0;
    nrd = 0; prev_en = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (a_m0_gnt && a_m1_gnt) bad++;
      if (a_mem_en && prev_en) bad++;
      if (a_mem_en != (a_m0_gnt || a_m1_gnt)) bad++;
      if (!a_mem_en && a_mem_we) bad++;
      prev_en = a_mem_en;
      if (a_m0_rvalid) begin
        chk("t6_rd0", {pd0, a_m0_rdata}, {1'b1, e0});
        pd0 = 0;
        nrd++;
      end
      if (a_m1_rvalid) begin
        chk("t6_rd1", {pd1, a_m1_rdata}, {1'b1, e1});
        pd1 = 0;
        nrd++;
      end
      if (a_m0_gnt) begin
        if (a_m0_we) sb[a_m0_addr[3:0]] = a_m0_wdata;
        else begin
          pd0 = 1;
          e0 = sb[a_m0_addr[3:0]];
        end
        w0 = 0;
        a_m0_req = 0;
      end else if (a_m0_req) begin
        w0++;
        if (w0 > maxw) maxw = w0;
      end
      if (a_m1_gnt) begin
        if (a_m1_we) sb[a_m1_addr[3:0]] = a_m1_wdata;
        else begin
          pd1 = 1;
          e1 = sb[a_m1_addr[3:0]];
        end
        w1 = 0;
        a_m1_req = 0;
      end else if (a_m1_req) begin
        w1++;
        if (w1 > maxw) maxw = w1;
      end
      if (c < 9980 && !a_m0_req && $urandom_range(0, 9) < 5) begin
        a_m0_req   = 1;
        a_m0_we    = 1'($urandom_range(0, 1));
        a_m0_addr  = 16'($urandom_range(0, 15));
        a_m0_wdata = 16'($urandom);
      end
      if (c < 9980 && !a_m1_req && $urandom_range(0, 9) < 5) begin
        a_m1_req   = 1;
        a_m1_we    = 1'($urandom_range(0, 1));
        a_m1_addr  = 16'($urandom_range(0, 15));
        a_m1_wdata = 16'($urandom);
      end
    end
    chk("t6_inv", bad, 0);
    chk("t6_pend", {pd0, pd1, a_m0_req, a_m1_req}, 0);
    chk("t6_starve", (maxw <= 12), 1);
    chk("t6_reads", (nrd > 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
